id_ex_stage_param: RTL and testbench

//  Parametrised decode stage plus ID/EX pipeline register for the 5-stage MIPS pipeline.

---
 rtl/mips_pkg.sv | 15 +
 rtl/gpr_file.sv | 41 ++++
 rtl/id_ex_stage_param.sv | 119 +++++++++++
 tb/tb_id_ex_stage_param.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS decode/ID-EX slice: opcodes, register-address
// width helper and the bubble value for the ID/EX valid flag.
package mips_pkg;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_LW  = 6'h23;

  localparam logic BUBBLE_VALID = 1'b0;

  function automatic int ra_w(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/gpr_file.sv
// General-purpose register file: two async read ports, one sync write port,
// write-first so a same-cycle WB write is visible on the read ports.
module gpr_file
  import mips_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = 1,
  localparam int RA_W     = ra_w(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] ra_a,
  input  logic [RA_W-1:0] ra_b,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_ok;

  assign wr_ok = we && !(ZERO_REG != 0 && wa == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // r0 check comes first so a WB to r0 never leaks through the bypass
  assign rd_a = (ZERO_REG != 0 && ra_a == '0) ? '0 :
                (we && wa == ra_a)             ? wd : regs[ra_a];
  assign rd_b = (ZERO_REG != 0 && ra_b == '0) ? '0 :
                (we && wa == ra_b)             ? wd : regs[ra_b];

endmodule

// File: rtl/id_ex_stage_param.sv
// Decode stage + ID/EX pipeline register: operand read, immediate extension,
// beq/j resolution with EX/MEM forwarding, load-use/branch hazard stall, stall counter.
module id_ex_stage_param
  import mips_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int CTRL_W   = 8,
  parameter  int ZERO_REG = 1,
  parameter  int BR_STALL = 1,
  parameter  int CNT_W    = 16,
  localparam int RA_W     = ra_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              is_beq,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              exmem_we,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [XLEN-1:0]   exmem_data,
  output logic              stall,
  output logic              br_equal,
  output logic [XLEN-1:0]   br_target,
  output logic [XLEN-1:0]   jmp_target,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [XLEN-1:0]   ex_rs_data,
  output logic [XLEN-1:0]   ex_rt_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [RA_W-1:0] rs, rt, rd, ex_dest;
  logic [XLEN-1:0] imm, rs_rf, rt_rf, rs_fwd, rt_fwd;
  logic            lu, bh;
  logic            unused_opcode;

  assign rs  = instr[21 +: RA_W];
  assign rt  = instr[16 +: RA_W];
  assign rd  = instr[11 +: RA_W];
  assign imm = {{(XLEN-16){instr[15]}}, instr[15:0]};
  assign unused_opcode = ^instr[31:26];

  gpr_file #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_gpr (
    .clk  (clk),
    .rst  (rst),
    .ra_a (rs),
    .ra_b (rt),
    .rd_a (rs_rf),
    .rd_b (rt_rf),
    .we   (wb_we),
    .wa   (wb_addr),
    .wd   (wb_data)
  );

  // EX/MEM result beats the register file (which already folds in the WB bypass)
  always_comb begin
    rs_fwd = rs_rf;
    rt_fwd = rt_rf;
    if (exmem_we && exmem_rd == rs && rs != '0) rs_fwd = exmem_data;
    if (exmem_we && exmem_rd == rt && rt != '0) rt_fwd = exmem_data;
  end

  assign br_equal   = (rs_fwd == rt_fwd);
  assign br_target  = pc + (imm << 2);
  assign jmp_target = {pc[XLEN-1:28], instr[25:0], 2'b00};

  // loads target rt, everything else is presented with its destination in ex_rd
  assign ex_dest = ex_mem_read ? ex_rt : ex_rd;
  assign lu = ex_valid && ex_mem_read && ex_rt != '0 && (ex_rt == rs || ex_rt == rt);
  assign bh = (BR_STALL != 0) && is_beq && ex_valid && ex_reg_write &&
              ex_dest != '0 && (ex_dest == rs || ex_dest == rt);
  assign stall = lu | bh;

  always_ff @(posedge clk) begin
    if (rst || flush || stall) begin
      ex_valid     <= BUBBLE_VALID;
      ex_ctrl      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
    end else begin
      ex_valid     <= 1'b1;
      ex_ctrl      <= ctrl_in;
      ex_reg_write <= reg_write_in;
      ex_mem_read  <= mem_read_in;
      ex_rs_data   <= rs_rf;
      ex_rt_data   <= rt_rf;
      ex_imm       <= imm;
      ex_rs        <= rs;
      ex_rt        <= rt;
      ex_rd        <= rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                     stall_cnt <= '0;
    else if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_id_ex_stage_param.sv
// Directed bench for id_ex_stage_param: reset, WB bypass, load-use, branch
// forwarding/hazard, flush, and stall-counter saturation on a CNT_W=2 copy.
module tb_id_ex_stage_param;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc;
  logic [7:0]  ctrl_in;
  logic        reg_write_in, mem_read_in, is_beq, flush, wb_we, exmem_we;
  logic [4:0]  wb_addr, exmem_rd;
  logic [31:0] wb_data, exmem_data;

  logic        stall, br_equal, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] br_target, jmp_target, ex_rs_data, ex_rt_data, ex_imm;
  logic [7:0]  ex_ctrl;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] stall_cnt;

  logic        stall2, br_equal2, ex_valid2, ex_reg_write2, ex_mem_read2;
  logic [31:0] br_target2, jmp_target2, ex_rs_data2, ex_rt_data2, ex_imm2;
  logic [7:0]  ex_ctrl2;
  logic [4:0]  ex_rs2, ex_rt2, ex_rd2;
  logic [1:0]  cnt2;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_stage_param dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .ctrl_in(ctrl_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .is_beq(is_beq),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .stall(stall), .br_equal(br_equal), .br_target(br_target), .jmp_target(jmp_target),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall_cnt(stall_cnt)
  );

  id_ex_stage_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .ctrl_in(ctrl_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .is_beq(is_beq),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .stall(stall2), .br_equal(br_equal2), .br_target(br_target2), .jmp_target(jmp_target2),
    .ex_valid(ex_valid2), .ex_ctrl(ex_ctrl2), .ex_reg_write(ex_reg_write2),
    .ex_mem_read(ex_mem_read2), .ex_rs_data(ex_rs_data2), .ex_rt_data(ex_rt_data2),
    .ex_imm(ex_imm2), .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_rd(ex_rd2), .stall_cnt(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  initial begin
    rst = 1'b1; instr = rtype(5, 5, 9); pc = 32'h100; ctrl_in = 8'h5A;
    reg_write_in = 1'b1; mem_read_in = 1'b0; is_beq = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    exmem_we = 1'b0; exmem_rd = '0; exmem_data = '0;

    // reset
    tick(); tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_ctrl", ex_ctrl, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_rs_data", ex_rs_data, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    tick();
    chk("r5_read_zero", ex_rs_data, 0);
    chk("load_valid", ex_valid, 1);
    chk("load_ctrl", ex_ctrl, 8'h5A);
    chk("load_rd", ex_rd, 9);

    // write-first WB bypass into ID/EX
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5; instr = rtype(3, 0, 6);
    tick();
    wb_we = 1'b0;
    chk("wb_bypass", ex_rs_data, 32'hA5A5);
    chk("ex_rs", ex_rs, 3);

    // immediate sign extension and branch target
    instr = itype(6'h08, 3, 7, 16'hFFF0); pc = 32'h100;
    #1 chk("br_target", br_target, 32'hC0);
    tick();
    chk("imm_sext", ex_imm, 32'hFFFF_FFF0);
    chk("rs_from_rf", ex_rs_data, 32'hA5A5);
    chk("ex_rt", ex_rt, 7);

    // jump target
    instr = {OP_J, 26'h40}; pc = 32'h3000_0004;
    #1 chk("jmp_target", jmp_target, 32'h3000_0100);

    // load-use
    instr = itype(OP_LW, 3, 2, 16'h0); mem_read_in = 1'b1; ctrl_in = 8'h11; pc = 32'h100;
    tick();
    chk("lw_in_ex", ex_mem_read, 1);
    instr = rtype(2, 1, 4); mem_read_in = 1'b0; ctrl_in = 8'h22;
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctrl", ex_ctrl, 0);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_release", stall, 0);
    tick();
    chk("lu_issue_ctrl", ex_ctrl, 8'h22);
    chk("lu_issue_rd", ex_rd, 4);
    chk("lu_cnt_hold", stall_cnt, 1);

    // branch compare with forwarding (EX holds add r4)
    instr = itype(OP_BEQ, 1, 1, 16'h0); is_beq = 1'b1; reg_write_in = 1'b0;
    exmem_we = 1'b1; exmem_rd = 5'd1; exmem_data = 32'd7;
    #1 chk("beq_self", br_equal, 1);
    chk("beq_no_stall", stall, 0);
    instr = itype(OP_BEQ, 1, 3, 16'h0); exmem_data = 32'hA5A5;
    #1 chk("beq_fwd_exmem", br_equal, 1);
    exmem_data = 32'd5; wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'hA5A5;
    #1 chk("beq_exmem_over_wb", br_equal, 0);
    exmem_we = 1'b0;
    #1 chk("beq_wb_bypass", br_equal, 1);
    wb_we = 1'b0;
    instr = itype(OP_BEQ, 0, 3, 16'h0); exmem_we = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hA5A5;
    #1 chk("beq_no_fwd_r0", br_equal, 0);
    exmem_we = 1'b0;

    // branch-operand hazard on r4
    instr = itype(OP_BEQ, 4, 3, 16'h0);
    #1 chk("bh_stall", stall, 1);
    tick();
    chk("bh_cnt", stall_cnt, 2);
    chk("bh_bubble", ex_valid, 0);
    is_beq = 1'b0;

    // flush, then flush together with stall
    instr = rtype(2, 1, 4); ctrl_in = 8'h33; reg_write_in = 1'b1; flush = 1'b1;
    tick();
    chk("flush_valid", ex_valid, 0);
    chk("flush_ctrl", ex_ctrl, 0);
    chk("flush_regwr", ex_reg_write, 0);
    flush = 1'b0; instr = itype(OP_LW, 3, 2, 16'h0); mem_read_in = 1'b1; ctrl_in = 8'h11;
    tick();
    instr = rtype(2, 1, 4); mem_read_in = 1'b0; flush = 1'b1;
    #1 chk("flush_stall", stall, 1);
    tick();
    chk("fs_bubble", ex_valid, 0);
    chk("fs_cnt", stall_cnt, 3);
    flush = 1'b0;

    // counter saturation: five stall cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_cnt", stall_cnt, 0);
    chk("rst2_cnt_small", cnt2, 0);
    for (int i = 0; i < 5; i++) begin
      instr = itype(OP_LW, 3, 2, 16'h0); mem_read_in = 1'b1;
      tick();
      instr = rtype(2, 1, 4); mem_read_in = 1'b0;
      tick();
    end
    chk("cnt16_five", stall_cnt, 5);
    chk("cnt2_sat", cnt2, 3);

    // reset while stalling
    instr = itype(OP_LW, 3, 2, 16'h0); mem_read_in = 1'b1;
    tick();
    instr = rtype(2, 1, 4); mem_read_in = 1'b0;
    #1 chk("pre_rst_stall", stall, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_cnt", stall_cnt, 0);
    chk("mid_rst_cnt_small", cnt2, 0);
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_stall", stall, 0);
    rst = 1'b0; instr = rtype(3, 0, 6);
    tick();
    chk("rf_cleared", ex_rs_data, 0);
    chk("post_rst_valid", ex_valid, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
